// File: rtl/next_state_sequencer_pkg.sv
// Shared encodings for the microsequencer: next-state modes, condition
// sources, instruction opcode/funct values and the control states that
// the instruction decoder dispatches to.
package sequencer_pkg;

    localparam int unsigned STATE_W     = 7;
    localparam int unsigned TIMEOUT     = 15;
    localparam logic [6:0]  FAULT_STATE = 7'd0;

    // Next-state mode carried in the microword n_sel field
    typedef enum logic [2:0] {
        N_DECODE = 3'd0,
        N_FETCH  = 3'd1,
        N_JUMP   = 3'd2,
        N_INC    = 3'd3,
        N_BRANCH = 3'd4,
        N_WAIT   = 3'd5,
        N_CALL   = 3'd6,
        N_RETURN = 3'd7
    } n_sel_e;

    // Condition source carried in the microword cond_sel field (5..7 = true)
    typedef enum logic [2:0] {
        C_MOC   = 3'd0,
        C_ZERO  = 3'd1,
        C_NEG   = 3'd2,
        C_CARRY = 3'd3,
        C_OVF   = 3'd4
    } cond_sel_e;

    // Primary opcodes (ir[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (ir[5:0])
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;

    // Control states entered from decode
    localparam logic [6:0] S_ADDU    = 7'd6;
    localparam logic [6:0] S_LW      = 7'd7;
    localparam logic [6:0] S_SW      = 7'd8;
    localparam logic [6:0] S_BEQ     = 7'd11;
    localparam logic [6:0] S_J       = 7'd12;
    localparam logic [6:0] S_ADDIU   = 7'd16;
    localparam logic [6:0] S_SUBU    = 7'd17;
    localparam logic [6:0] S_AND     = 7'd19;
    localparam logic [6:0] S_OR      = 7'd21;
    localparam logic [6:0] S_LUI     = 7'd30;
    localparam logic [6:0] S_ILLEGAL = 7'd0;

endpackage

// File: rtl/next_state_sequencer_opcode_encoder.sv
// Combinational instruction decoder: maps the instruction register to the
// first control state of its microroutine and flags anything unlisted.
module opcode_encoder
    import sequencer_pkg::*;
(
    input  logic [31:0]        ir,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    logic [5:0] opcode_s;
    logic [5:0] funct_s;

    assign opcode_s = ir[31:26];
    assign funct_s  = ir[5:0];

    // Opcode/funct lookup; unknown encodings land on state 0 with illegal set
    always_comb begin
        state   = S_ILLEGAL;
        illegal = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    F_ADDU:  state = S_ADDU;
                    F_SUBU:  state = S_SUBU;
                    F_AND:   state = S_AND;
                    F_OR:    state = S_OR;
                    default: begin
                        state   = S_ILLEGAL;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_LW:    state = S_LW;
            OP_SW:    state = S_SW;
            OP_BEQ:   state = S_BEQ;
            OP_J:     state = S_J;
            OP_ADDIU: state = S_ADDIU;
            OP_LUI:   state = S_LUI;
            default: begin
                state   = S_ILLEGAL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/next_state_sequencer.sv
// Microsequencer: owns the control-state register that indexes the
// Microstore and picks the next state from the active microword's
// sequencing fields. Also keeps a one-deep return address, a memory-wait
// watchdog, and single-cycle illegal-opcode / timeout pulses.
module next_state_sequencer #(
    parameter int unsigned        STATE_W     = sequencer_pkg::STATE_W,
    parameter int unsigned        TIMEOUT     = sequencer_pkg::TIMEOUT,
    parameter logic [STATE_W-1:0] FAULT_STATE = sequencer_pkg::FAULT_STATE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ir,
    input  logic [2:0]         n_sel,
    input  logic [2:0]         cond_sel,
    input  logic               inv,
    input  logic [STATE_W-1:0] cr_addr,
    input  logic               moc,
    input  logic               zero,
    input  logic               neg,
    input  logic               carry,
    input  logic               ovf,
    output logic [STATE_W-1:0] current_state,
    output logic               illegal_op,
    output logic               mem_timeout
);

    import sequencer_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;

    logic [STATE_W-1:0] enc_state_s;
    logic               enc_illegal_s;
    logic [STATE_W-1:0] inc_s;
    logic               cond_raw_s;
    logic               cond_s;

    opcode_encoder u_encoder (
        .ir      (ir),
        .state   (enc_state_s),
        .illegal (enc_illegal_s)
    );

    // Wraps naturally at 2^STATE_W
    assign inc_s = state_q + {{(STATE_W-1){1'b0}}, 1'b1};

    // Condition selection; unused selector codes read as always-true
    always_comb begin
        cond_raw_s = 1'b1;
        case (cond_sel)
            C_MOC:   cond_raw_s = moc;
            C_ZERO:  cond_raw_s = zero;
            C_NEG:   cond_raw_s = neg;
            C_CARRY: cond_raw_s = carry;
            C_OVF:   cond_raw_s = ovf;
            default: cond_raw_s = 1'b1;
        endcase
        cond_s = cond_raw_s ^ inv;
    end

    // Next-state selection, return-address capture, wait watchdog and pulses
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        wait_cnt_d = '0;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;
        case (n_sel)
            N_DECODE: begin
                state_d   = enc_state_s;
                illegal_d = enc_illegal_s;
            end
            N_FETCH:  state_d = '0;
            N_JUMP:   state_d = cr_addr;
            N_INC:    state_d = inc_s;
            N_BRANCH: begin
                if (cond_s) begin
                    state_d = cr_addr;
                end else begin
                    state_d = inc_s;
                end
            end
            N_WAIT: begin
                // A condition arriving on the last allowed cycle still wins
                if (cond_s) begin
                    state_d = inc_s;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = FAULT_STATE;
                    timeout_d = 1'b1;
                end else begin
                    state_d    = state_q;
                    wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            N_CALL: begin
                state_d = cr_addr;
                ret_d   = inc_s;
            end
            N_RETURN: state_d = ret_q;
            default:  state_d = state_q;
        endcase
    end

    // Register update with synchronous reset taking priority over every mode
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '0;
            ret_q      <= '0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    assign current_state = state_q;
    assign illegal_op    = illegal_q;
    assign mem_timeout   = timeout_q;

endmodule

// File: tb/tb_next_state_sequencer.sv
// Self-checking bench for next_state_sequencer: directed scenarios plus a
// randomized run against a behavioural model of the sequencing rules.
module tb_next_state_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir;
    logic [2:0]  n_sel;
    logic [2:0]  cond_sel;
    logic        inv;
    logic [6:0]  cr_addr;
    logic        moc, zero, neg, carry, ovf;
    logic [6:0]  current_state;
    logic        illegal_op;
    logic        mem_timeout;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_state, m_ret, m_wait;
    bit m_ill, m_to;

    next_state_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .ir            (ir),
        .n_sel         (n_sel),
        .cond_sel      (cond_sel),
        .inv           (inv),
        .cr_addr       (cr_addr),
        .moc           (moc),
        .zero          (zero),
        .neg           (neg),
        .carry         (carry),
        .ovf           (ovf),
        .current_state (current_state),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_decode(input logic [31:0] v, output int st, output bit il);
        int op, f;
        op = int'(v[31:26]);
        f  = int'(v[5:0]);
        il = 1'b0;
        st = 0;
        if (op == 0) begin
            if      (f == 'h21) st = 6;
            else if (f == 'h23) st = 17;
            else if (f == 'h24) st = 19;
            else if (f == 'h25) st = 21;
            else il = 1'b1;
        end
        else if (op == 'h23) st = 7;
        else if (op == 'h2B) st = 8;
        else if (op == 'h04) st = 11;
        else if (op == 'h02) st = 12;
        else if (op == 'h09) st = 16;
        else if (op == 'h0F) st = 30;
        else il = 1'b1;
    endfunction

    // Advance the model by one clock using the currently driven inputs
    task automatic model_step();
        bit c;
        int inc, nxt, dst;
        bit dil;
        case (cond_sel)
            3'd0: c = moc;
            3'd1: c = zero;
            3'd2: c = neg;
            3'd3: c = carry;
            3'd4: c = ovf;
            default: c = 1'b1;
        endcase
        c   = c ^ inv;
        inc = (m_state + 1) % 128;
        m_ill = 1'b0;
        m_to  = 1'b0;
        if (reset) begin
            m_state = 0; m_ret = 0; m_wait = 0;
        end else begin
            nxt = m_state;
            if (n_sel == 3'd5 && !c) begin
                if (m_wait == 14) begin
                    nxt = 0; m_to = 1'b1; m_wait = 0;
                end else begin
                    m_wait = m_wait + 1;
                end
            end else begin
                m_wait = 0;
                case (n_sel)
                    3'd0: begin model_decode(ir, dst, dil); nxt = dst; m_ill = dil; end
                    3'd1: nxt = 0;
                    3'd2: nxt = int'(cr_addr);
                    3'd3: nxt = inc;
                    3'd4: nxt = c ? int'(cr_addr) : inc;
                    3'd5: nxt = inc;
                    3'd6: begin nxt = int'(cr_addr); m_ret = inc; end
                    default: nxt = m_ret;
                endcase
            end
            m_state = nxt;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [2:0] n, input logic [2:0] cs, input logic iv, input logic [6:0] cr);
        n_sel = n; cond_sel = cs; inv = iv; cr_addr = cr;
    endtask

    task automatic test_reset();
        reset = 1'b1; ir = 32'd0; moc = 1'b0; zero = 1'b0; neg = 1'b0; carry = 1'b0; ovf = 1'b0;
        set_in(3'd1, 3'd0, 1'b0, 7'd0);
        tick(); tick();
        reset = 1'b0;
        total++; if (current_state !== 7'd0 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
            bad++; $display("FAIL reset_init: state=%0d ill=%b to=%b want 0/0/0", current_state, illegal_op, mem_timeout); end
        // Build ret_reg=4 and wait_cnt=5, then reset while CALL is presented
        set_in(3'd2, 3'd0, 1'b0, 7'd3); tick();
        set_in(3'd6, 3'd0, 1'b0, 7'd40); tick();
        set_in(3'd5, 3'd0, 1'b0, 7'd0); moc = 1'b0;
        repeat (5) tick();
        set_in(3'd6, 3'd0, 1'b0, 7'd50); reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total++; if (current_state !== 7'd0 || illegal_op !== 1'b0 || mem_timeout !== 1'b0) begin
            bad++; $display("FAIL reset_midcall: state=%0d ill=%b to=%b want 0/0/0", current_state, illegal_op, mem_timeout); end
        // wait_cnt must restart from 0: 14 holds before the timeout
        set_in(3'd5, 3'd0, 1'b0, 7'd0); moc = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            total++; if (mem_timeout !== 1'b0) begin
                bad++; $display("FAIL reset_waitcnt hold %0d: timeout=%b want 0", i, mem_timeout); end
        end
        tick();
        total++; if (mem_timeout !== 1'b1) begin
            bad++; $display("FAIL reset_waitcnt expire: timeout=%b want 1", mem_timeout); end
        set_in(3'd7, 3'd0, 1'b0, 7'd0); tick();
        total++; if (current_state !== 7'd0) begin
            bad++; $display("FAIL reset_retreg: state=%0d want 0", current_state); end
    endtask

    task automatic test_decode();
        set_in(3'd1, 3'd0, 1'b0, 7'd0); tick();
        ir = {6'h23, 26'd0}; set_in(3'd0, 3'd0, 1'b0, 7'd0); tick();
        total++; if (current_state !== 7'd7 || illegal_op !== 1'b0) begin
            bad++; $display("FAIL decode_lw: state=%0d ill=%b want 7/0", current_state, illegal_op); end
        ir = {6'h00, 20'd0, 6'h3F}; tick();
        total++; if (current_state !== 7'd0 || illegal_op !== 1'b1) begin
            bad++; $display("FAIL decode_illegal: state=%0d ill=%b want 0/1", current_state, illegal_op); end
        set_in(3'd3, 3'd0, 1'b0, 7'd0); tick();
        total++; if (current_state !== 7'd1 || illegal_op !== 1'b0) begin
            bad++; $display("FAIL decode_pulse_clear: state=%0d ill=%b want 1/0", current_state, illegal_op); end
        ir = {6'h00, 20'd0, 6'h25}; set_in(3'd0, 3'd0, 1'b0, 7'd0); tick();
        total++; if (current_state !== 7'd21) begin
            bad++; $display("FAIL decode_or: state=%0d want 21", current_state); end
        ir = {6'h0F, 26'h3FFFFFF}; tick();
        total++; if (current_state !== 7'd30) begin
            bad++; $display("FAIL decode_lui: state=%0d want 30", current_state); end
    endtask

    task automatic test_wait();
        set_in(3'd2, 3'd0, 1'b0, 7'd9); tick();
        set_in(3'd5, 3'd0, 1'b0, 7'd0); moc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (current_state !== 7'd9) begin
                bad++; $display("FAIL wait_hold %0d: state=%0d want 9", i, current_state); end
        end
        moc = 1'b1; tick();
        total++; if (current_state !== 7'd10 || mem_timeout !== 1'b0) begin
            bad++; $display("FAIL wait_release: state=%0d to=%b want 10/0", current_state, mem_timeout); end
    endtask

    task automatic test_timeout();
        set_in(3'd2, 3'd0, 1'b0, 7'd9); moc = 1'b0; tick();
        set_in(3'd5, 3'd0, 1'b0, 7'd0);
        for (int i = 0; i < 14; i++) begin
            tick();
            total++; if (current_state !== 7'd9 || mem_timeout !== 1'b0) begin
                bad++; $display("FAIL timeout_hold %0d: state=%0d to=%b want 9/0", i, current_state, mem_timeout); end
        end
        tick();
        total++; if (current_state !== 7'd0 || mem_timeout !== 1'b1) begin
            bad++; $display("FAIL timeout_fault: state=%0d to=%b want 0/1", current_state, mem_timeout); end
        set_in(3'd3, 3'd0, 1'b0, 7'd0); tick();
        total++; if (current_state !== 7'd1 || mem_timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_pulse_clear: state=%0d to=%b want 1/0", current_state, mem_timeout); end
        // Condition arriving on the final allowed cycle beats the timeout
        set_in(3'd2, 3'd0, 1'b0, 7'd9); tick();
        set_in(3'd5, 3'd0, 1'b0, 7'd0);
        repeat (14) tick();
        moc = 1'b1; tick();
        total++; if (current_state !== 7'd10 || mem_timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_cond_wins: state=%0d to=%b want 10/0", current_state, mem_timeout); end
        moc = 1'b0;
    endtask

    task automatic test_branch();
        set_in(3'd2, 3'd0, 1'b0, 7'd11); tick();
        zero = 1'b1; set_in(3'd4, 3'd1, 1'b1, 7'd20); tick();
        total++; if (current_state !== 7'd12) begin
            bad++; $display("FAIL branch_not_taken: state=%0d want 12", current_state); end
        set_in(3'd2, 3'd0, 1'b0, 7'd11); tick();
        zero = 1'b0; set_in(3'd4, 3'd1, 1'b1, 7'd20); tick();
        total++; if (current_state !== 7'd20) begin
            bad++; $display("FAIL branch_taken: state=%0d want 20", current_state); end
        set_in(3'd4, 3'd6, 1'b0, 7'd99); tick();
        total++; if (current_state !== 7'd99) begin
            bad++; $display("FAIL branch_always: state=%0d want 99", current_state); end
    endtask

    task automatic test_call_return();
        set_in(3'd2, 3'd0, 1'b0, 7'd3); tick();
        set_in(3'd6, 3'd0, 1'b0, 7'd40); tick();
        total++; if (current_state !== 7'd40) begin
            bad++; $display("FAIL call_target: state=%0d want 40", current_state); end
        set_in(3'd3, 3'd0, 1'b0, 7'd0); tick();
        set_in(3'd7, 3'd0, 1'b0, 7'd0); tick();
        total++; if (current_state !== 7'd4) begin
            bad++; $display("FAIL return_addr: state=%0d want 4", current_state); end
        tick();
        total++; if (current_state !== 7'd4) begin
            bad++; $display("FAIL return_again: state=%0d want 4", current_state); end
        set_in(3'd2, 3'd0, 1'b0, 7'd50); tick();
        set_in(3'd6, 3'd0, 1'b0, 7'd60); tick();
        set_in(3'd6, 3'd0, 1'b0, 7'd70); tick();
        set_in(3'd7, 3'd0, 1'b0, 7'd0); tick();
        total++; if (current_state !== 7'd61) begin
            bad++; $display("FAIL call_overwrite: state=%0d want 61", current_state); end
        set_in(3'd2, 3'd0, 1'b0, 7'd127); tick();
        set_in(3'd3, 3'd0, 1'b0, 7'd0); tick();
        total++; if (current_state !== 7'd0) begin
            bad++; $display("FAIL inc_wrap: state=%0d want 0", current_state); end
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        logic [5:0] fns [5];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h09, 6'h0F};
        fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h3F};
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            n_sel = 3'($urandom_range(0, 7));
            cond_sel = 3'($urandom_range(0, 7));
            inv = 1'($urandom);
            cr_addr = 7'($urandom);
            moc = ($urandom_range(0, 7) == 0);
            zero = 1'($urandom); neg = 1'($urandom); carry = 1'($urandom); ovf = 1'($urandom);
            if ($urandom_range(0, 3) == 0) ir = $urandom;
            else ir = {ops[$urandom_range(0, 6)], 20'($urandom), fns[$urandom_range(0, 4)]};
            tick();
            total++; if (int'(current_state) != m_state || illegal_op !== m_ill || mem_timeout !== m_to) begin
                bad++; $display("FAIL random cycle %0d: state=%0d ill=%b to=%b want %0d/%b/%b",
                                i, current_state, illegal_op, mem_timeout, m_state, m_ill, m_to); end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_state = 0; m_ret = 0; m_wait = 0; m_ill = 1'b0; m_to = 1'b0;
        test_reset();
        test_decode();
        test_wait();
        test_timeout();
        test_branch();
        test_call_return();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
